alu_multicycle: RTL



---
 rtl/alu_pkg.sv | 30 +++
 rtl/mul_iter.sv | 108 ++++++++++
 rtl/alu_multicycle.sv | 112 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl op codes, multiplier FSM state encoding, default width.
// Imported by the ALU control decoder, alu_multicycle and mul_iter so all agree on the codes.
// Contents: ALU_* localparams, state_t enum (IDLE, MUL), WIDTH_DEFAULT, is_mul_op helper.
package alu_pkg;

   localparam int WIDTH_DEFAULT = 32;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_MUL  = 4'b1000;
   localparam logic [3:0] ALU_MULH = 4'b1001;
   localparam logic [3:0] ALU_SLL  = 4'b1010;
   localparam logic [3:0] ALU_SRA  = 4'b1011;
   localparam logic [3:0] ALU_SRL  = 4'b1100;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_t;

   function automatic logic is_mul_op(input logic [3:0] code);
      return (code == ALU_MUL) || (code == ALU_MULH);
   endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles in MUL state.
// Latency: done pulses in the WIDTH-th MUL cycle with product valid combinationally alongside it.
// Backpressure: start is only honoured in IDLE; busy=1 while iterating and starts are dropped.
// Ports: clk, reset (async, active-high), start, op_a, op_b, is_signed (take magnitudes and
//        fix sign at the end), hi_sel (return upper half), busy, done, product.
module mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             is_signed,
   input  logic             hi_sel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic                 neg_q, neg_d;
   logic                 hi_q, hi_d;

   logic [WIDTH-1:0]     addend;
   logic [WIDTH:0]       upper_sum;
   logic [2*WIDTH-1:0]   acc_step;
   logic [2*WIDTH-1:0]   acc_final;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         hi_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         hi_q     <= hi_d;
      end
   end

   // One iteration: conditionally add into the upper half keeping the carry-out,
   // then shift the whole accumulator right so the carry lands in the top bit.
   always_comb begin
      addend    = mplier_q[0] ? mcand_q : '0;
      upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      acc_step  = {upper_sum, acc_q[WIDTH-1:1]};
      acc_final = neg_q ? -acc_step : acc_step;
      product   = hi_q ? acc_final[2*WIDTH-1:WIDTH] : acc_final[WIDTH-1:0];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      hi_d     = hi_q;
      done     = 1'b0;
      busy     = (state_q == MUL);

      case (state_q)
         IDLE: begin
            if (start) begin
               // Signed multiply works on magnitudes; -2^(W-1) negates to itself,
               // which is its correct unsigned magnitude.
               mcand_d  = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
               mplier_d = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
               neg_d    = is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
               hi_d     = hi_sel;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = MUL;
            end
         end
         MUL: begin
            acc_d    = acc_step;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               done    = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/shift/compare/add/sub, iterative MUL/MULH via mul_iter.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL/MULH (start edge to valid cycle).
// Backpressure: busy=1 during a multiply; starts seen while busy are dropped, upstream must stall.
// Ports: clk, reset (async, active-high), start, ALUControl[3:0], SrcA, SrcB -> ALUResult, Zero,
//        busy, valid (one-cycle pulse per accepted op), illegal (pulses with valid on unknown code).
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       ALUControl,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic             busy,
   output logic             valid,
   output logic             illegal
);

   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             valid_q, valid_d;
   logic             illegal_q, illegal_d;

   logic             mul_busy, mul_done;
   logic [WIDTH-1:0] mul_product;
   logic             accept, mul_sel, mul_start, mulh_sel;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] single_res;
   logic             single_ill;

   assign accept    = start && !mul_busy;
   assign mul_sel   = is_mul_op(ALUControl);
   assign mul_start = accept && mul_sel;
   assign mulh_sel  = (ALUControl == ALU_MULH);
   assign shamt     = SrcB[SHW-1:0];

   mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .reset     (reset),
      .start     (mul_start),
      .op_a      (SrcA),
      .op_b      (SrcB),
      .is_signed (mulh_sel),
      .hi_sel    (mulh_sel),
      .busy      (mul_busy),
      .done      (mul_done),
      .product   (mul_product)
   );

   always_comb begin
      single_res = '0;
      single_ill = 1'b0;
      case (ALUControl)
         ALU_ADD:  single_res = SrcA + SrcB;
         ALU_SUB:  single_res = SrcA - SrcB;
         ALU_AND:  single_res = SrcA & SrcB;
         ALU_OR:   single_res = SrcA | SrcB;
         ALU_XOR:  single_res = SrcA ^ SrcB;
         ALU_SLT:  single_res[0] = ($signed(SrcA) < $signed(SrcB));
         ALU_SLTU: single_res[0] = (SrcA < SrcB);
         ALU_SLL:  single_res = SrcA << shamt;
         ALU_SRL:  single_res = SrcA >> shamt;
         ALU_SRA:  single_res = $unsigned($signed(SrcA) >>> shamt);
         ALU_MUL, ALU_MULH: single_res = '0;
         default:  single_ill = 1'b1;
      endcase
   end

   // mul_done can only fire while the multiplier is busy, and accept needs it idle,
   // so the two result sources never collide.
   always_comb begin
      result_d  = result_q;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      if (mul_done) begin
         result_d = mul_product;
         valid_d  = 1'b1;
      end else if (accept && !mul_sel) begin
         result_d  = single_res;
         valid_d   = 1'b1;
         illegal_d = single_ill;
      end
      zero_d = (result_d == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q  <= '0;
         zero_q    <= 1'b1;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         result_q  <= result_d;
         zero_q    <= zero_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
      end
   end

   assign ALUResult = result_q;
   assign Zero      = zero_q;
   assign valid     = valid_q;
   assign illegal   = illegal_q;
   assign busy      = mul_busy;

endmodule
